// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit: shift-add multiply or restoring divide, one bit per cycle, results into HI/LO.
// Optional macro MULDIV_ZERO_SKIP_EN: multiplies with a zero operand complete the cycle after acceptance.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state, state_nx;
  logic [CW-1:0]    cnt;
  logic [1:0]       op_q;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] a_raw;
  logic [2*WIDTH-1:0] acc;
  logic             neg_q, neg_r, bz;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] v, input logic sgn);
    return (sgn && v[WIDTH-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_2w(input logic [2*WIDTH-1:0] v, input logic en);
    return en ? (~v + 1'b1) : v;
  endfunction

  logic accept, skip;
  assign accept = (state == IDLE) && start;
  assign busy   = (state != IDLE);

`ifdef MULDIV_ZERO_SKIP_EN
  assign skip = accept && !op[1] && ((a == '0) || (b == '0));
`else
  assign skip = 1'b0;
`endif

  logic [WIDTH-1:0] a_mag, b_mag;
  assign a_mag = mag(a, op[0]);
  assign b_mag = mag(b, op[0]);

  // acc holds {partial product high, multiplier} for multiply and {remainder, quotient} for divide.
  logic [WIDTH:0]     mul_sum, trial;
  logic [2*WIDTH-1:0] mul_next, div_next;
  assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : '0)};
  assign mul_next = {mul_sum, acc[WIDTH-1:1]};
  assign trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
  assign div_next = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                 : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

  logic [2*WIDTH-1:0] mul_res;
  logic [WIDTH-1:0]   hi_fix, lo_fix;
  assign mul_res = neg_2w(acc, neg_q);
  assign hi_fix  = op_q[1] ? (bz ? a_raw : neg_w(acc[2*WIDTH-1:WIDTH], neg_r)) : mul_res[2*WIDTH-1:WIDTH];
  assign lo_fix  = op_q[1] ? (bz ? '1    : neg_w(acc[WIDTH-1:0], neg_q))       : mul_res[WIDTH-1:0];

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept && !skip) state_nx = CALC;
      CALC:    if (cnt == '0) state_nx = FIX;
      FIX:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // Counter starts at WIDTH: WIDTH iterations plus one settle cycle give a WIDTH+2 edge latency.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      op_q  <= '0;
      opnd  <= '0;
      a_raw <= '0;
      acc   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bz    <= 1'b0;
    end else if (accept && !skip) begin
      cnt   <= CW'(WIDTH);
      op_q  <= op;
      opnd  <= op[1] ? b_mag : a_mag;
      acc   <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
      a_raw <= a;
      neg_q <= op[0] && (a[WIDTH-1] ^ b[WIDTH-1]);
      neg_r <= op[0] && op[1] && a[WIDTH-1];
      bz    <= (b == '0);
    end else if (state == CALC && cnt != '0) begin
      cnt <= cnt - 1'b1;
      acc <= op_q[1] ? div_next : mul_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi          <= '0;
      lo          <= '0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done        <= (state == FIX) || skip;
      div_by_zero <= (state == FIX) && op_q[1] && bz;
      if (state == FIX) begin
        hi <= hi_fix;
        lo <= lo_fix;
      end else if (skip) begin
        hi <= '0;
        lo <= '0;
      end else if (state == IDLE && !start) begin
        if (hi_we) hi <= wdata;
        if (lo_we) lo <= wdata;
      end
    end
  end

endmodule
